// File: rtl/logic_eval_arbiter_pkg.sv
// rtl/logic_eval_arbiter_pkg.sv - shared constants and types for the logic evaluator arbiter
package logic_eval_arbiter_pkg;

   localparam int LE_OPW = 4;

   // Truth table of out = ~(((a&b)|~c)&d), indexed by {a,b,c,d}
   localparam logic [15:0] LE_GOLDEN_TT = 16'h5DDD;

   localparam int LE_BIT_A = 3;
   localparam int LE_BIT_B = 2;
   localparam int LE_BIT_C = 1;
   localparam int LE_BIT_D = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DONE  = 2'd2
   } st_state_t;

endpackage

// File: rtl/logic_eval_arbiter_if.sv
// rtl/logic_eval_arbiter_if.sv - request/response bundle between requesters, arbiter and result sink
interface logic_eval_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [4*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic                 rsp_out;
   logic [3:0]           rsp_data;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out, rsp_data
   );
endinterface

// File: rtl/logic_eval_arbiter_core.sv
// rtl/logic_eval_arbiter_core.sv - combinational 4-input evaluator out = ~(((a&b)|~c)&d)
module logic_eval_core
   import logic_eval_arbiter_pkg::*;
(
   input  logic [LE_OPW-1:0] op,
   output logic              out
);
   assign out = ~(((op[LE_BIT_A] & op[LE_BIT_B]) | ~op[LE_BIT_C]) & op[LE_BIT_D]);
endmodule

// File: rtl/logic_eval_arbiter.sv
// rtl/logic_eval_arbiter.sv - round-robin sharing of one logic evaluator with a registered tagged response
// Optional self-test sweep enabled by LOGIC_EVAL_SELF_TEST_EN.
module logic_eval_arbiter
   import logic_eval_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
)(
   input  logic clk,
   input  logic rst_n,
`ifdef LOGIC_EVAL_SELF_TEST_EN
   input  logic st_start,
   output logic st_busy,
   output logic st_done,
   output logic st_pass,
`endif
   logic_eval_arbiter_if.slave bus
);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant;
   logic              any_valid;
   logic              accept;
   logic              take;
   logic              st_hold;
   logic [LE_OPW-1:0] sel_data;
   logic [LE_OPW-1:0] core_in;
   logic              core_out;

   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic              rsp_out_q;
   logic [LE_OPW-1:0] rsp_data_q;

   function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!any_valid && bus.req_valid[rot_idx(rr_ptr, k)]) begin
            any_valid = 1'b1;
            grant     = rot_idx(rr_ptr, k);
         end
      end
   end

   assign sel_data = bus.req_data[int'(grant)*LE_OPW +: LE_OPW];
   assign accept   = !rsp_valid_q || bus.rsp_ready;
   assign take     = accept && any_valid && !st_hold;

   always_comb begin
      bus.req_ready = '0;
      if (take) bus.req_ready[grant] = 1'b1;
   end

`ifdef LOGIC_EVAL_SELF_TEST_EN
   st_state_t         st_state, st_next;
   logic [LE_OPW-1:0] st_vec, st_vec_next;
   logic              st_mis, st_mis_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_state <= ST_IDLE;
         st_vec   <= '0;
         st_mis   <= 1'b0;
      end else begin
         st_state <= st_next;
         st_vec   <= st_vec_next;
         st_mis   <= st_mis_next;
      end
   end

   always_comb begin
      st_next     = st_state;
      st_vec_next = st_vec;
      st_mis_next = st_mis;
      case (st_state)
         ST_IDLE, ST_DONE: begin
            if (st_start) begin
               st_next     = ST_SWEEP;
               st_vec_next = '0;
               st_mis_next = 1'b0;
            end
         end
         ST_SWEEP: begin
            if (core_out != LE_GOLDEN_TT[st_vec]) st_mis_next = 1'b1;
            st_vec_next = st_vec + 1'b1;
            if (st_vec == 4'd15) st_next = ST_DONE;
         end
         default: st_next = ST_IDLE;
      endcase
   end

   assign st_hold = (st_state == ST_SWEEP);
   assign st_busy = st_hold;
   assign st_done = (st_state == ST_DONE);
   assign st_pass = st_done && !st_mis;
   // The sweep owns the shared evaluator; requesters are stalled meanwhile
   assign core_in = st_hold ? st_vec : sel_data;
`else
   assign st_hold = 1'b0;
   assign core_in = sel_data;
`endif

   logic_eval_core u_core (
      .op  (core_in),
      .out (core_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_out_q   <= 1'b0;
         rsp_data_q  <= '0;
         rr_ptr      <= '0;
      end else if (take) begin
         rsp_valid_q <= 1'b1;
         rsp_id_q    <= grant;
         rsp_out_q   <= core_out;
         rsp_data_q  <= sel_data;
         rr_ptr      <= (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_out   = rsp_out_q;
   assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_logic_eval_arbiter.sv
// tb/tb_logic_eval_arbiter.sv - directed vector bench for logic_eval_arbiter (optionally LOGIC_EVAL_SELF_TEST_EN)
module tb_logic_eval_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic_eval_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

`ifdef LOGIC_EVAL_SELF_TEST_EN
   logic st_start, st_busy, st_done, st_pass;
   logic_eval_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_start(st_start), .st_busy(st_busy), .st_done(st_done), .st_pass(st_pass),
      .bus(bus)
   );
`else
   logic_eval_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  rv;
      logic [15:0] rd;
      logic        rr;
      logic [3:0]  ready;
      logic        valid;
      logic [1:0]  id;
      logic        out;
      logic [3:0]  data;
   } vec_t;

   vec_t tbl[13];
   logic [15:0] gold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic model(input logic [3:0] v);
      return ~(((v[3] & v[2]) | ~v[1]) & v[0]);
   endfunction

   initial begin
      gold = 16'h5DDD;
      tbl[0]  = '{4'b0001, 16'h000D, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 4'hD};
      tbl[1]  = '{4'b0000, 16'h000D, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'hD};
      tbl[2]  = '{4'b1111, 16'h3F08, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0};
      tbl[3]  = '{4'b1111, 16'h3F08, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'hF};
      tbl[4]  = '{4'b1111, 16'h3F08, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 4'h3};
      tbl[5]  = '{4'b1111, 16'h3F08, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'h8};
      tbl[6]  = '{4'b1111, 16'h3F08, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 4'h0};
      tbl[7]  = '{4'b1111, 16'h3F08, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'h0};
      tbl[8]  = '{4'b1111, 16'h3F08, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'h0};
      tbl[9]  = '{4'b0100, 16'h3F08, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 4'hF};
      tbl[10] = '{4'b0001, 16'h3F08, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1, 4'h8};
      tbl[11] = '{4'b1000, 16'h3F08, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'h8};
      tbl[12] = '{4'b0000, 16'h3F08, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'h8};

      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
`ifdef LOGIC_EVAL_SELF_TEST_EN
      st_start = 1'b0;
`endif
      #3;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("reset_rsp_id",    32'(bus.rsp_id),    0);
      chk("reset_rsp_out",   32'(bus.rsp_out),   0);
      chk("reset_rsp_data",  32'(bus.rsp_data),  0);
      chk("reset_req_ready", 32'(bus.req_ready), 0);
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         bus.req_valid = tbl[i].rv;
         bus.req_data  = tbl[i].rd;
         bus.rsp_ready = tbl[i].rr;
         #1;
         chk($sformatf("tbl%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
         tick();
         chk($sformatf("tbl%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl%0d_rsp_id", i),    32'(bus.rsp_id),    32'(tbl[i].id));
         chk($sformatf("tbl%0d_rsp_out", i),   32'(bus.rsp_out),   32'(tbl[i].out));
         chk($sformatf("tbl%0d_rsp_data", i),  32'(bus.rsp_data),  32'(tbl[i].data));
      end

      bus.rsp_ready = 1'b1;
      bus.req_valid = 4'b0100;
      for (int v = 0; v < 16; v++) begin
         bus.req_data = 16'(v) << 8;
         tick();
         chk($sformatf("exh%0d_valid", v), 32'(bus.rsp_valid), 1);
         chk($sformatf("exh%0d_id", v),    32'(bus.rsp_id),    2);
         chk($sformatf("exh%0d_data", v),  32'(bus.rsp_data),  32'(v));
         chk($sformatf("exh%0d_out", v),   32'(bus.rsp_out),   32'(gold[v]));
         chk($sformatf("exh%0d_model", v), 32'(bus.rsp_out),   32'(model(4'(v))));
      end

      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("midreset_rsp_data",  32'(bus.rsp_data),  0);
      bus.req_valid = '0;
      tick();
      rst_n = 1'b1;

      bus.req_valid = 4'b1111;
      bus.req_data  = 16'h3F08;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("fair%0d_ready", i), 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
         tick();
         chk($sformatf("fair%0d_valid", i), 32'(bus.rsp_valid), 1);
         chk($sformatf("fair%0d_id", i),    32'(bus.rsp_id),    32'(i % 4));
         chk($sformatf("fair%0d_data", i),  32'(bus.rsp_data),  32'((16'h3F08 >> (4 * (i % 4))) & 16'hF));
      end

      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_ready", i), 32'(bus.req_ready), 0);
         tick();
         chk($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid), 1);
         chk($sformatf("bp%0d_id", i),    32'(bus.rsp_id),    1);
         chk($sformatf("bp%0d_data", i),  32'(bus.rsp_data),  0);
         chk($sformatf("bp%0d_out", i),   32'(bus.rsp_out),   1);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(bus.req_ready), 32'(4'b0100));
      tick();
      chk("bp_release_id",   32'(bus.rsp_id),   2);
      chk("bp_release_data", 32'(bus.rsp_data), 32'hF);

`ifdef LOGIC_EVAL_SELF_TEST_EN
      begin
         int busy_cnt;
         busy_cnt = 0;
         chk("st_idle_done", 32'(st_done), 0);
         st_start = 1'b1;
         tick();
         st_start = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (st_busy) begin
               busy_cnt++;
               chk($sformatf("st%0d_ready", i), 32'(bus.req_ready), 0);
               tick();
            end
         end
         chk("st_busy_cycles", 32'(busy_cnt), 16);
         chk("st_done", 32'(st_done), 1);
         chk("st_pass", 32'(st_pass), 1);
         tick();
         chk("st_done_held", 32'(st_done), 1);
      end
`endif

      bus.req_valid = '0;
      tick();
      chk("final_drain_valid", 32'(bus.rsp_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
